stage_if: RTL and testbench
===========================

STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 Parameter: RESET_PC, 32'hBFC00000, fetch address after reset.
REQ-002 Parameter: ACK_TIMEOUT, 255, maximum cycles spent in WAIT before a bus-error exception is raised.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  downstream decode stage cannot accept; the output register holds its value.
REQ-006 branch_valid  in  1  single-cycle pulse; branch_dest applies after the delay-slot fetch.
REQ-007 branch_dest  in  32  branch target address.
REQ-008 exc_jump  in  1  single-cycle pulse; exception/ERET redirect that flushes fetch.
REQ-009 exc_jump_addr  in  32  handler or EPC address.
REQ-010 mem_req  out  1  instruction-bus request.
REQ-011 mem_addr  out  32  instruction-bus address.
REQ-012 mem_ack  in  1  bus returns mem_rdata/mem_exc this cycle.
REQ-013 mem_rdata  in  32  fetched word.
REQ-014 mem_exc  in  `EXC_CODE_WIDTH  fetch fault code (TLB miss etc.); `EC_NONE if none.
REQ-015 instr  out  32  instruction to decode.
REQ-016 next_pc  out  32  fetch address of instr + 4.
REQ-017 exc_code  out  `EXC_CODE_WIDTH  fetch exception for instr; `EC_NONE if none.
REQ-018 exc_addr  out  32  faulting fetch address.
REQ-019 in_delay_slot  out  1  instr was fetched immediately after a branch_valid pulse.

Function
REQ-020 FSM states: ISSUE, WAIT, HOLD.
REQ-021 ISSUE: if pc[1:0]!=0, no request; outputs exc_code=`EC_ADEL, exc_addr=pc, instr=0; go to ISSUE at pc+4 (HOLD if stall).
REQ-022 ISSUE with aligned pc: mem_req=1, mem_addr=pc for exactly one cycle; go to WAIT.
REQ-023 WAIT: mem_req=0; a 8-bit counter increments each cycle; on reaching ACK_TIMEOUT, output exc_code=`EC_IBE, exc_addr=pc, go to ISSUE.
REQ-024 WAIT with mem_ack and !stall: instr<=mem_rdata, next_pc<=pc+4, exc_code<=mem_exc, exc_addr<=pc; go to ISSUE.
REQ-025 WAIT with mem_ack and stall: capture the word into an internal buffer; go to HOLD; mem_ack never lost.
REQ-026 HOLD: output registers unchanged; on !stall, transfer the buffer to the outputs; go to ISSUE.
REQ-027 Sequential pc update: pc<=pc+4 on each completed fetch; 32-bit wrap (32'hFFFFFFFC+4=0) is permitted.
REQ-028 branch_valid: latch branch_dest into pending_target, set pending flag; the fetch after the one in progress (the delay slot) uses pending_target; clear the flag on use.
REQ-029 in_delay_slot=1 for the instruction whose fetch was in progress or next issued when branch_valid pulsed; 0 otherwise.
REQ-030 exc_jump: highest priority; set pc<=exc_jump_addr; clear pending flag and HOLD buffer.
REQ-031 exc_jump while in WAIT: the outstanding ack is still awaited but its data is discarded; output instr=0, exc_code=`EC_NONE.
REQ-032 exc_jump and branch_valid in the same cycle: ignore branch_valid.
REQ-033 Discarded or not-yet-valid slots present instr=0 (NOP) with exc_code=`EC_NONE.
REQ-034 Fetch exceptions (mem_exc!=`EC_NONE) are forwarded to exc_code; pc still advances to pc+4; decode/exception logic issues exc_jump.

Reset
REQ-035 On rst: pc=RESET_PC, state=ISSUE, mem_req=0, mem_addr=0, instr=0, next_pc=RESET_PC, exc_code=`EC_NONE, exc_addr=0, in_delay_slot=0, pending flag=0, timeout counter=0.
REQ-036 rst in WAIT abandons the transaction; a late mem_ack after reset is ignored until the first ISSUE.
REQ-037 First mem_req occurs in the first cycle after rst deasserts, with mem_addr=RESET_PC.

Verification
REQ-038 Reset, ack after 1 cycle returning 32'h24010005 -> mem_addr=BFC00000; instr=24010005, next_pc=BFC00004; next request to BFC00004.
REQ-039 Stall held 3 cycles during mem_ack -> instr unchanged for 3 cycles, then the buffered word appears; no second request until it is consumed.
REQ-040 branch_valid with branch_dest=80000100 during fetch of BFC00008 -> BFC0000C fetched with in_delay_slot=1; next fetch at 80000100 with in_delay_slot=0.
REQ-041 exc_jump to 80000180 while in WAIT -> the acked word is dropped (instr=0); next mem_addr=80000180.
REQ-042 Branch to 80000102 -> no mem_req; exc_code=`EC_ADEL, exc_addr=80000102.
REQ-043 mem_exc=`EC_TLBL on ack at 00400000 -> exc_code=`EC_TLBL, exc_addr=00400000; no ack for 255 cycles afterwards -> `EC_IBE.

Source files
------------

// File: rtl/stage_if.sv
// Instruction fetch stage: single-outstanding fetch FSM with delayed-branch
// redirect, exception redirect, ack timeout and a one-entry stall buffer.
`ifndef EXC_CODE_WIDTH
`define EXC_CODE_WIDTH 5
`endif
`ifndef EC_NONE
`define EC_NONE 5'h1F
`endif
`ifndef EC_TLBL
`define EC_TLBL 5'h02
`endif
`ifndef EC_ADEL
`define EC_ADEL 5'h04
`endif
`ifndef EC_IBE
`define EC_IBE 5'h06
`endif

module stage_if #(
  parameter logic [31:0] RESET_PC    = 32'hBFC00000,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       branch_valid,
  input  logic [31:0]                branch_dest,
  input  logic                       exc_jump,
  input  logic [31:0]                exc_jump_addr,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata,
  input  logic [`EXC_CODE_WIDTH-1:0] mem_exc,
  output logic [31:0]                instr,
  output logic [31:0]                next_pc,
  output logic [`EXC_CODE_WIDTH-1:0] exc_code,
  output logic [31:0]                exc_addr,
  output logic                       in_delay_slot
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [31:0]                instr;
    logic [31:0]                npc;
    logic [`EXC_CODE_WIDTH-1:0] exc;
    logic [31:0]                addr;
    logic                       ds;
  } fetch_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [7:0]  cnt, cnt_n;
  // 2: the fetch in flight completes normally, then the delay slot follows
  // 1: the next completed fetch is the delay slot; redirect after it
  logic [1:0]  pend_cnt, pend_cnt_n, pend_eff;
  logic [31:0] pend_tgt, pend_tgt_n, tgt_eff;
  logic        discard, discard_n;
  fetch_t      hold_buf, hold_buf_n, out_r, out_n, res;
  logic        done, loaded, aligned, timeout, br;

  assign aligned  = (pc[1:0] == 2'b00);
  assign timeout  = (cnt == 8'(ACK_TIMEOUT - 1));
  assign br       = branch_valid && !exc_jump;
  assign pend_eff = br ? ((state == WAIT) ? 2'd2 : 2'd1) : pend_cnt;
  assign tgt_eff  = br ? branch_dest : pend_tgt;

  // Bus request is issued straight from ISSUE; a redirect in the same cycle cancels it.
  assign mem_req  = !rst && (state == ISSUE) && aligned && !exc_jump;
  assign mem_addr = mem_req ? pc : 32'h0;

  assign instr         = out_r.instr;
  assign next_pc       = out_r.npc;
  assign exc_code      = out_r.exc;
  assign exc_addr      = out_r.addr;
  assign in_delay_slot = out_r.ds;

  // Next-state, pc sequencing and output/buffer loading.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    cnt_n      = cnt;
    pend_cnt_n = pend_eff;
    pend_tgt_n = tgt_eff;
    discard_n  = discard;
    hold_buf_n = hold_buf;
    out_n      = out_r;
    done       = 1'b0;
    loaded     = 1'b0;
    res.instr  = 32'h0;
    res.npc    = pc + 32'd4;
    res.exc    = `EC_NONE;
    res.addr   = pc;
    res.ds     = (pend_eff == 2'd1);

    if (exc_jump) begin
      pc_n       = exc_jump_addr;
      pend_cnt_n = 2'd0;
      if (state == WAIT) begin
        // keep waiting for the outstanding ack, but throw its data away
        discard_n = 1'b1;
        if (mem_ack || timeout) state_n = ISSUE;
        else                    cnt_n   = cnt + 8'd1;
      end else begin
        state_n = ISSUE;
      end
    end else begin
      case (state)
        ISSUE: begin
          if (!aligned) begin
            res.exc = `EC_ADEL;
            done    = 1'b1;
          end else begin
            state_n   = WAIT;
            cnt_n     = 8'd0;
            discard_n = 1'b0;
          end
        end
        WAIT: begin
          if (mem_ack || timeout) begin
            if (discard) begin
              state_n = ISSUE;
            end else begin
              res.instr = mem_ack ? mem_rdata : 32'h0;
              res.exc   = mem_ack ? mem_exc : `EC_IBE;
              done      = 1'b1;
            end
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        HOLD: begin
          if (!stall) begin
            out_n   = hold_buf;
            loaded  = 1'b1;
            state_n = ISSUE;
          end
        end
        default: state_n = ISSUE;
      endcase
    end

    if (done) begin
      if (pend_eff == 2'd1) begin
        pc_n       = tgt_eff;
        pend_cnt_n = 2'd0;
      end else begin
        pc_n = pc + 32'd4;
        if (pend_eff == 2'd2) pend_cnt_n = 2'd1;
      end
      if (stall) begin
        hold_buf_n = res;
        state_n    = HOLD;
      end else begin
        out_n   = res;
        loaded  = 1'b1;
        state_n = ISSUE;
      end
    end

    // decode took the previous word and nothing new is ready: present a NOP
    if (!stall && !loaded) begin
      out_n.instr = 32'h0;
      out_n.exc   = `EC_NONE;
      out_n.ds    = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ISSUE;
      pc        <= RESET_PC;
      cnt       <= 8'd0;
      pend_cnt  <= 2'd0;
      pend_tgt  <= 32'h0;
      discard   <= 1'b0;
      hold_buf  <= '0;
      out_r.instr <= 32'h0;
      out_r.npc   <= RESET_PC;
      out_r.exc   <= `EC_NONE;
      out_r.addr  <= 32'h0;
      out_r.ds    <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      cnt      <= cnt_n;
      pend_cnt <= pend_cnt_n;
      pend_tgt <= pend_tgt_n;
      discard  <= discard_n;
      hold_buf <= hold_buf_n;
      out_r    <= out_n;
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: vector table for the main flow plus
// hand-written timeout, stall and reset-during-wait sequences.
`ifndef EXC_CODE_WIDTH
`define EXC_CODE_WIDTH 5
`endif
`ifndef EC_NONE
`define EC_NONE 5'h1F
`endif
`ifndef EC_TLBL
`define EC_TLBL 5'h02
`endif
`ifndef EC_ADEL
`define EC_ADEL 5'h04
`endif
`ifndef EC_IBE
`define EC_IBE 5'h06
`endif

module tb_stage_if;
  localparam logic [4:0] N = `EC_NONE;
  localparam logic [4:0] A = `EC_ADEL;
  localparam logic [4:0] T = `EC_TLBL;
  localparam logic [4:0] I = `EC_IBE;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stall = 1'b0, branch_valid = 1'b0, exc_jump = 1'b0, mem_ack = 1'b0;
  logic [31:0] branch_dest = '0, exc_jump_addr = '0, mem_rdata = '0;
  logic [`EXC_CODE_WIDTH-1:0] mem_exc = N;
  logic        mem_req, in_delay_slot;
  logic [31:0] mem_addr, instr, next_pc, exc_addr;
  logic [`EXC_CODE_WIDTH-1:0] exc_code;

  int ncmp = 0;
  int nbad = 0;

  stage_if dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_valid(branch_valid), .branch_dest(branch_dest),
    .exc_jump(exc_jump), .exc_jump_addr(exc_jump_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_exc(mem_exc),
    .instr(instr), .next_pc(next_pc), .exc_code(exc_code),
    .exc_addr(exc_addr), .in_delay_slot(in_delay_slot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, bv;
    logic [31:0] bd;
    logic        ej;
    logic [31:0] ea;
    logic        ack;
    logic [31:0] rd;
    logic [4:0]  mx;
    logic        req;
    logic [31:0] addr, ins, npc;
    logic [4:0]  exc;
    logic [31:0] eaddr;
    logic        ds;
  } vec_t;

  vec_t tv[26];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // one cycle: drive at the falling edge, settle, then the caller checks
  task automatic cyc(input logic r, input logic s, input logic bv, input logic [31:0] bd,
                     input logic ej, input logic [31:0] ea, input logic ack,
                     input logic [31:0] rd, input logic [4:0] mx);
    @(negedge clk);
    rst = r; stall = s; branch_valid = bv; branch_dest = bd;
    exc_jump = ej; exc_jump_addr = ea; mem_ack = ack; mem_rdata = rd; mem_exc = mx;
    #1;
  endtask

  task automatic idle(input logic s);
    cyc(1'b0, s, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, N);
  endtask

  task automatic chk_all(input string p, input logic req, input logic [31:0] addr,
                         input logic [31:0] ins, input logic [31:0] npc, input logic [4:0] exc,
                         input logic [31:0] eaddr, input logic ds);
    chk({p, ".mem_req"}, {31'h0, mem_req}, {31'h0, req});
    chk({p, ".mem_addr"}, mem_addr, addr);
    chk({p, ".instr"}, instr, ins);
    chk({p, ".next_pc"}, next_pc, npc);
    chk({p, ".exc_code"}, {27'h0, exc_code}, {27'h0, exc});
    chk({p, ".exc_addr"}, exc_addr, eaddr);
    chk({p, ".in_delay_slot"}, {31'h0, in_delay_slot}, {31'h0, ds});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        rst s  bv bd            ej ea            ack rd            mx  req addr          instr         npc           exc eaddr         ds
    tv[0]  = '{1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  0, 32'h0,        32'h0,        32'hBFC00000, N, 32'h0,        0};
    tv[1]  = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  1, 32'hBFC00000, 32'h0,        32'hBFC00000, N, 32'h0,        0};
    tv[2]  = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h24010005, N,  0, 32'h0,        32'h0,        32'hBFC00000, N, 32'h0,        0};
    tv[3]  = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  1, 32'hBFC00004, 32'h24010005, 32'hBFC00004, N, 32'hBFC00000, 0};
    tv[4]  = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h11111111, N,  0, 32'h0,        32'h0,        32'hBFC00004, N, 32'hBFC00000, 0};
    tv[5]  = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  1, 32'hBFC00008, 32'h11111111, 32'hBFC00008, N, 32'hBFC00004, 0};
    tv[6]  = '{0, 0, 1, 32'h80000100, 0, 32'h0,        0, 32'h0,        N,  0, 32'h0,        32'h0,        32'hBFC00008, N, 32'hBFC00004, 0};
    tv[7]  = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h22222222, N,  0, 32'h0,        32'h0,        32'hBFC00008, N, 32'hBFC00004, 0};
    tv[8]  = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  1, 32'hBFC0000C, 32'h22222222, 32'hBFC0000C, N, 32'hBFC00008, 0};
    tv[9]  = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h33333333, N,  0, 32'h0,        32'h0,        32'hBFC0000C, N, 32'hBFC00008, 0};
    tv[10] = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  1, 32'h80000100, 32'h33333333, 32'hBFC00010, N, 32'hBFC0000C, 1};
    tv[11] = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h44444444, N,  0, 32'h0,        32'h0,        32'hBFC00010, N, 32'hBFC0000C, 0};
    tv[12] = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  1, 32'h80000104, 32'h44444444, 32'h80000104, N, 32'h80000100, 0};
    tv[13] = '{0, 0, 0, 32'h0,        1, 32'h80000180, 0, 32'h0,        N,  0, 32'h0,        32'h0,        32'h80000104, N, 32'h80000100, 0};
    tv[14] = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h55555555, N,  0, 32'h0,        32'h0,        32'h80000104, N, 32'h80000100, 0};
    tv[15] = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  1, 32'h80000180, 32'h0,        32'h80000104, N, 32'h80000100, 0};
    tv[16] = '{0, 0, 1, 32'h80000102, 0, 32'h0,        1, 32'h66666666, N,  0, 32'h0,        32'h0,        32'h80000104, N, 32'h80000100, 0};
    tv[17] = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  1, 32'h80000184, 32'h66666666, 32'h80000184, N, 32'h80000180, 0};
    tv[18] = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h77777777, N,  0, 32'h0,        32'h0,        32'h80000184, N, 32'h80000180, 0};
    tv[19] = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  0, 32'h0,        32'h77777777, 32'h80000188, N, 32'h80000184, 1};
    tv[20] = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  0, 32'h0,        32'h0,        32'h80000106, A, 32'h80000102, 0};
    tv[21] = '{0, 0, 0, 32'h0,        1, 32'h00400000, 0, 32'h0,        N,  0, 32'h0,        32'h0,        32'h8000010A, A, 32'h80000106, 0};
    tv[22] = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  1, 32'h00400000, 32'h0,        32'h8000010A, N, 32'h80000106, 0};
    tv[23] = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h88888888, T,  0, 32'h0,        32'h0,        32'h8000010A, N, 32'h80000106, 0};
    tv[24] = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  1, 32'h00400004, 32'h88888888, 32'h00400004, T, 32'h00400000, 0};
    tv[25] = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        N,  0, 32'h0,        32'h0,        32'h00400004, N, 32'h00400000, 0};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 26; i++) begin
      cyc(tv[i].rst, tv[i].stall, tv[i].bv, tv[i].bd, tv[i].ej, tv[i].ea, tv[i].ack, tv[i].rd, tv[i].mx);
      chk_all($sformatf("row%0d", i), tv[i].req, tv[i].addr, tv[i].ins, tv[i].npc, tv[i].exc, tv[i].eaddr, tv[i].ds);
    end

    // ack timeout: WAIT entered at row 24, row 25 was the first waiting cycle
    repeat (253) idle(1'b0);
    idle(1'b0);
    chk("pre_timeout.exc_code", {27'h0, exc_code}, {27'h0, N});
    chk("pre_timeout.mem_req", {31'h0, mem_req}, 32'h0);
    idle(1'b0);
    chk_all("timeout", 1'b1, 32'h00400008, 32'h0, 32'h00400008, I, 32'h00400004, 1'b0);

    // stall across an ack: word buffered, no new request until consumed
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hAAAAAAAA, N);
    chk("stall_s1.mem_req", {31'h0, mem_req}, 32'h0);
    idle(1'b1);
    chk("stall_s2.instr", instr, 32'hAAAAAAAA);
    chk("stall_s2.mem_addr", mem_addr, 32'h0040000C);
    cyc(0, 1, 0, 0, 0, 0, 1, 32'hBBBBBBBB, N);
    chk("stall_s3.instr", instr, 32'hAAAAAAAA);
    chk("stall_s3.mem_req", {31'h0, mem_req}, 32'h0);
    idle(1'b1);
    chk("stall_s4.instr", instr, 32'hAAAAAAAA);
    chk("stall_s4.mem_req", {31'h0, mem_req}, 32'h0);
    idle(1'b0);
    chk("stall_s5.instr", instr, 32'hAAAAAAAA);
    chk("stall_s5.mem_req", {31'h0, mem_req}, 32'h0);
    idle(1'b0);
    chk_all("stall_s6", 1'b1, 32'h00400010, 32'hBBBBBBBB, 32'h00400010, N, 32'h0040000C, 1'b0);

    // reset while waiting; a late ack right after reset is ignored
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h0, N);
    chk("rst_wait.mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_wait.mem_addr", mem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, N);
    chk_all("post_rst", 1'b1, 32'hBFC00000, 32'h0, 32'hBFC00000, N, 32'h0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hCCCCCCCC, N);
    chk("late_ack.instr", instr, 32'h0);
    chk("late_ack.mem_req", {31'h0, mem_req}, 32'h0);
    idle(1'b0);
    chk_all("post_rst_fetch", 1'b1, 32'hBFC00004, 32'hCCCCCCCC, 32'hBFC00004, N, 32'hBFC00000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
